adc_spi_responder: RTL
======================

# adc_spi_responder

SPI responder (slave) that implements the fast-ADC configuration register map: 16-bit frames made of a R/W bit, a 7-bit address and 8 data bits, MSB first. It is the target end of the ADC configuration SPI bus. Uses: a board-level ADC model for simulation and loopback test of the initiator, and a configuration port on a companion FPGA. Decoded register fields drive data format, sleep and test-pattern outputs directly.

## Interface
- NUM_REGS, 5, number of implemented registers (addresses 0..NUM_REGS-1).
- TRANSFER_SIZE, 16, bits per frame; fixed at 16, other values unsupported.
- clk  in  1  system clock; SCK/CS/SDI are oversampled on it.
- rst  in  1  reset; asynchronous, active-low.
- sck_in  in  1  SPI clock, idle low, mode 0.
- cs_in  in  1  chip select, active-low.
- sdi_in  in  1  serial data from initiator.
- sdo_out  out  1  serial read data.
- sdo_oe  out  1  high while sdo_out is driven (read data phase).
- fmt_twos  out  1  reg1[5]: 1 = two's-complement output format.
- sleep  out  1  reg1[4]: 1 = sleep.
- tp_en  out  1  reg2[2]: 1 = test pattern enabled.
- tp_pattern  out  16  {reg3, reg4}.
- wr_strobe  out  1  one-cycle pulse per committed write.
- wr_addr  out  7  address of the last committed write.
- wr_data  out  8  data of the last committed write.
- frame_err  out  1  one-cycle pulse on an aborted or overlong frame.

## Operation
- sck_in, cs_in and sdi_in each pass through a 2-flop synchronizer. Rise and fall of SCK are detected from the synchronized value against a 1-cycle-delayed copy.
- State machine:
  - IDLE: cs_s high. cs_s low → CMD with bitcnt=0.
  - CMD: shift sdi_s in on each SCK rise. On the 8th rise, latch rw=bit15 and addr=bits14:8, then go to DATA. If rw=1, load the read shift register with reg[addr], or 0x00 if addr ≥ NUM_REGS.
  - DATA, read: on each SCK fall, present the next read bit MSB first; the first fall after the 8th rise presents bit 7.
  - DATA, write: shift in data bits. On the 16th rise, commit and go to DONE.
  - DONE: further SCK rises set an overrun flag but are otherwise ignored. cs_s high → IDLE; frame_err pulses if overrun is set.
  - CS rising in CMD or DATA: frame_err pulses, nothing is committed, go to IDLE.
- Commit rules:
  - addr < NUM_REGS, addr ≠ 0: reg[addr] ← data. wr_strobe pulses; wr_addr/wr_data update.
  - addr 0 with data[7]=1: soft reset; all registers cleared to 0x00. wr_strobe pulses.
  - addr 0 with data[7]=0: registers unchanged. wr_strobe pulses.
  - reg0 always reads 0x00.
  - addr ≥ NUM_REGS: ignored, no wr_strobe.
- Read frames never modify registers and never strobe.
- sdo_oe is 1 from the first SCK fall after the 8th rise of a read frame until cs_s rises. It is 0 otherwise. sdo_out is 0 whenever sdo_oe is 0.
- rst asserted, from any state including mid-frame: all registers 0x00, state IDLE, synchronizers cleared. All outputs 0: sdo_out, sdo_oe, fmt_twos, sleep, tp_en, tp_pattern, wr_strobe, wr_addr, wr_data, frame_err.

## Timing
- Pin-to-action latency is 3 clk edges: 2 synchronizer stages, then the registered action on the edge where the detected SCK/CS edge is valid.
- Register outputs (fmt_twos, sleep, tp_en, tp_pattern) and wr_strobe/wr_addr/wr_data update on the same clk edge, 3 edges after the 16th SCK rise at the pin. wr_strobe is high for exactly 1 cycle.
- sdo_out is registered and valid 3 clk edges after the SCK fall at the pin.
- Constraint: each SCK high and low phase must last ≥ 4 clk periods, i.e. SCK ≤ clk/8. CS setup to the first SCK rise must be ≥ 4 clk periods.
- SCK rise and CS rise detected in the same cycle: the CS rise wins and the frame is aborted.
- frame_err is high for exactly 1 cycle, 3 edges after the CS rise at the pin.

## Test plan
- Write frame 0x0120 → one wr_strobe with wr_addr=1, wr_data=0x20; then fmt_twos=1, sleep=0.
- Write 0x0130, then read frame 0x81xx → sdo_out shifts 0,0,1,1,0,0,0,0 on bits 8–15; sdo_oe high only during that phase; registers unchanged; no wr_strobe.
- Write 0x03B3, 0x0417, 0x0204 → tp_pattern=0xB317, tp_en=1. Then write 0x0080 → all outputs 0; a read of address 0 returns 0x00.
- Deassert CS after 10 bits of 0x0130 → frame_err pulses once, sleep stays 0, no wr_strobe. 17 SCKs on a write frame → the write commits, then frame_err pulses at CS rise.
- Assert rst mid-frame after 12 bits of 0x0130 → all outputs 0 immediately (asynchronous). The next full write 0x0110 after release sets sleep=1.
- Read frame 0x90xx (addr 0x10) → sdo_out all 0; write 0x1055 → no wr_strobe, no register change.

Source files
------------

// File: rtl/adc_spi_responder.sv
`timescale 1ns/1ps
// adc_spi_responder
//   SPI responder for the fast-ADC configuration register map. Each frame is
//   16 bits, MSB first: {rw, addr[6:0], data[7:0]}. SCK/CS/SDI are
//   oversampled on clk through 2-flop synchronizers. Decoded register
//   fields drive the data-format, sleep and test-pattern outputs directly.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   sck_in     SPI clock (mode 0, idle low)
//   cs_in      chip select, active-low
//   sdi_in     serial data from the initiator
//   sdo_out    serial read data (0 whenever sdo_oe is 0)
//   sdo_oe     high while read data is being driven
//   fmt_twos   reg1[5], two's-complement output format
//   sleep      reg1[4], sleep request
//   tp_en      reg2[2], test pattern enable
//   tp_pattern {reg3, reg4}
//   wr_strobe  one-cycle pulse per committed write
//   wr_addr    address of the last committed write
//   wr_data    data of the last committed write
//   frame_err  one-cycle pulse on an aborted or overlong frame
module adc_spi_responder #(
  parameter int NUM_REGS      = 5,
  parameter int TRANSFER_SIZE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck_in,
  input  logic        cs_in,
  input  logic        sdi_in,
  output logic        sdo_out,
  output logic        sdo_oe,
  output logic        fmt_twos,
  output logic        sleep,
  output logic        tp_en,
  output logic [15:0] tp_pattern,
  output logic        wr_strobe,
  output logic [6:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_err
);

  localparam int CNT_W = $clog2(TRANSFER_SIZE);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TRANSFER_SIZE - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(7);
  localparam logic [6:0]       NREGS_A  = 7'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  // Synchronizers
  logic sck_meta_q, sck_s_q, sck_d1_q;
  logic cs_meta_q, cs_s_q;
  logic sdi_meta_q, sdi_s_q;

  // Frame state
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              rw_q, rw_d;
  logic [6:0]        addr_q, addr_d;
  logic [7:0]        rd_shift_q, rd_shift_d;
  logic              sdo_q, sdo_d;
  logic              sdo_oe_q, sdo_oe_d;
  logic              overrun_q, overrun_d;

  // Register file and write reporting
  logic [NUM_REGS-1:0][7:0] regs_q, regs_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [6:0]        wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              frame_err_q, frame_err_d;

  logic       sck_rise, sck_fall;
  logic [6:0] cmd_addr;
  logic [7:0] rd_byte;
  logic [7:0] wr_byte;
  logic       commit;

  assign sck_rise = sck_s_q & ~sck_d1_q;
  assign sck_fall = ~sck_s_q & sck_d1_q;

  // Command byte as it stands after the current (8th) rise
  assign cmd_addr = {shift_q[5:0], sdi_s_q};
  // Data byte as it stands after the current (16th) rise
  assign wr_byte  = {shift_q[6:0], sdi_s_q};

  // Read mux; out-of-range addresses read as zero, reg0 is never written
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == 7'(i)) begin
        rd_byte = regs_q[i];
      end
    end
  end

  // CS synchronizer resets to the deasserted level so that leaving reset
  // does not look like a frame start followed by an abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_meta_q <= 1'b0;
      sck_s_q    <= 1'b0;
      sck_d1_q   <= 1'b0;
      cs_meta_q  <= 1'b1;
      cs_s_q     <= 1'b1;
      sdi_meta_q <= 1'b0;
      sdi_s_q    <= 1'b0;
    end else begin
      sck_meta_q <= sck_in;
      sck_s_q    <= sck_meta_q;
      sck_d1_q   <= sck_s_q;
      cs_meta_q  <= cs_in;
      cs_s_q     <= cs_meta_q;
      sdi_meta_q <= sdi_in;
      sdi_s_q    <= sdi_meta_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; CS deassertion takes priority over a coincident SCK rise
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!cs_s_q) state_d = S_CMD;
      S_CMD: begin
        if (cs_s_q) state_d = S_IDLE;
        else if (sck_rise && bitcnt_q == CMD_LAST) state_d = S_DATA;
      end
      S_DATA: begin
        if (cs_s_q) state_d = S_IDLE;
        else if (sck_rise && bitcnt_q == LAST_BIT) state_d = S_DONE;
      end
      S_DONE: if (cs_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    rd_shift_d  = rd_shift_q;
    sdo_d       = sdo_q;
    sdo_oe_d    = sdo_oe_q;
    overrun_d   = overrun_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    commit      = 1'b0;

    case (state_q)
      S_IDLE: begin
        bitcnt_d  = '0;
        overrun_d = 1'b0;
        sdo_d     = 1'b0;
        sdo_oe_d  = 1'b0;
      end
      S_CMD: begin
        if (cs_s_q) begin
          frame_err_d = 1'b1;
        end else if (sck_rise) begin
          shift_d  = wr_byte;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == CMD_LAST) begin
            rw_d       = shift_q[6];
            addr_d     = cmd_addr;
            rd_shift_d = shift_q[6] ? rd_byte : 8'h00;
          end
        end
      end
      S_DATA: begin
        if (cs_s_q) begin
          frame_err_d = 1'b1;
          sdo_d       = 1'b0;
          sdo_oe_d    = 1'b0;
        end else if (sck_rise) begin
          shift_d  = wr_byte;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == LAST_BIT && !rw_q) begin
            commit = 1'b1;
          end
        end else if (sck_fall && rw_q) begin
          // Mode 0: the initiator samples on the next rise
          sdo_d      = rd_shift_q[7];
          sdo_oe_d   = 1'b1;
          rd_shift_d = {rd_shift_q[6:0], 1'b0};
        end
      end
      S_DONE: begin
        if (cs_s_q) begin
          frame_err_d = overrun_q;
          sdo_d       = 1'b0;
          sdo_oe_d    = 1'b0;
        end else if (sck_rise) begin
          overrun_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Write commit: addr 0 is a control address (bit 7 = soft reset)
    if (commit && addr_q < NREGS_A) begin
      wr_strobe_d = 1'b1;
      wr_addr_d   = addr_q;
      wr_data_d   = wr_byte;
      if (addr_q == 7'd0) begin
        if (wr_byte[7]) regs_d = '0;
      end else begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (addr_q == 7'(i)) regs_d[i] = wr_byte;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitcnt_q    <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      rd_shift_q  <= '0;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
      overrun_q   <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      rd_shift_q  <= rd_shift_d;
      sdo_q       <= sdo_d;
      sdo_oe_q    <= sdo_oe_d;
      overrun_q   <= overrun_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign sdo_out    = sdo_q & sdo_oe_q;
  assign sdo_oe     = sdo_oe_q;
  assign fmt_twos   = regs_q[1][5];
  assign sleep      = regs_q[1][4];
  assign tp_en      = regs_q[2][2];
  assign tp_pattern = {regs_q[3], regs_q[4]};
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_err  = frame_err_q;

endmodule
